// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch-stage program-counter generator:
// default widths, reset vector and redirect channel indices.
package pc_gen_pkg;

  localparam int unsigned ADDR_W_DEF    = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam int unsigned NUM_REDIR_DEF = 3;

  localparam int unsigned REDIR_TRAP   = 0;
  localparam int unsigned REDIR_JUMP   = 1;
  localparam int unsigned REDIR_BRANCH = 2;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_gen_redir_prio_sel.sv
// Fixed-priority redirect selector: channel 0 is the highest priority.
// Purely combinational; reports the winning index, its target and whether any channel requested.
module redir_prio_sel
  import pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned NUM_REDIR = NUM_REDIR_DEF,
  parameter int unsigned IDX_W     = idx_w(NUM_REDIR)
) (
  input  logic [NUM_REDIR-1:0]        i_en,
  input  logic [NUM_REDIR*ADDR_W-1:0] i_addr,
  output logic [IDX_W-1:0]            o_sel,
  output logic                        o_any,
  output logic [ADDR_W-1:0]           o_addr
);

  // Scan from lowest to highest priority so the lowest enabled index is the last one written.
  always_comb begin
    o_any  = 1'b0;
    o_sel  = '0;
    o_addr = '0;
    for (int k = NUM_REDIR - 1; k >= 0; k--) begin
      o_any  = o_any | i_en[k];
      o_sel  = i_en[k] ? IDX_W'(k) : o_sel;
      o_addr = i_en[k] ? i_addr[k*ADDR_W +: ADDR_W] : o_addr;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator with prioritised redirects, a one-deep
// deferred redirect held across stalls, and misaligned-target flagging.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W     = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(RESET_VEC_DEF),
  parameter int unsigned       NUM_REDIR  = NUM_REDIR_DEF,
  parameter int unsigned       INC        = 4,
  parameter int unsigned       ALIGN_BITS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall_i,
  input  logic                        fetch_ready_i,
  input  logic [NUM_REDIR-1:0]        redir_en_i,
  input  logic [NUM_REDIR*ADDR_W-1:0] redir_addr_i,
  output logic [ADDR_W-1:0]           pc_o,
  output logic                        pc_valid_o,
  output logic                        pend_o,
  output logic                        misalign_o,
  output logic [ADDR_W-1:0]           misalign_addr_o
);

  localparam int unsigned       IDX_W      = idx_w(NUM_REDIR);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);

  logic [ADDR_W-1:0] r_pc;
  logic              r_valid;
  logic              r_pend;
  logic [IDX_W-1:0]  r_pend_idx;
  logic [ADDR_W-1:0] r_pend_addr;
  logic              r_mis;
  logic [ADDR_W-1:0] r_mis_addr;

  logic [IDX_W-1:0]  w_sel;
  logic              w_any;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_adv;
  logic              w_hold;
  logic              w_pend_wins;
  logic              w_cand;
  logic [IDX_W-1:0]  w_tgt_idx;
  logic [ADDR_W-1:0] w_tgt;
  logic              w_tgt_mis;

  logic [ADDR_W-1:0] w_nxt_pc;
  logic              w_nxt_pend;
  logic [IDX_W-1:0]  w_nxt_pend_idx;
  logic [ADDR_W-1:0] w_nxt_pend_addr;
  logic              w_nxt_mis;
  logic [ADDR_W-1:0] w_nxt_mis_addr;

  redir_prio_sel #(
    .ADDR_W    (ADDR_W),
    .NUM_REDIR (NUM_REDIR),
    .IDX_W     (IDX_W)
  ) u_sel (
    .i_en   (redir_en_i),
    .i_addr (redir_addr_i),
    .o_sel  (w_sel),
    .o_any  (w_any),
    .o_addr (w_sel_addr)
  );

  // Candidate arbitration: a held redirect beats a new one only with strictly higher priority.
  always_comb begin
    w_adv       = r_valid & fetch_ready_i & ~stall_i;
    w_hold      = stall_i | ~fetch_ready_i;
    w_pend_wins = r_pend & (~w_any | (r_pend_idx < w_sel));
    w_cand      = w_any | r_pend;
    w_tgt       = w_pend_wins ? r_pend_addr : w_sel_addr;
    w_tgt_idx   = w_pend_wins ? r_pend_idx : w_sel;
    w_tgt_mis   = w_cand & (|(w_tgt & ALIGN_MASK));
  end

  // Next-state selection: misalign, load, defer, increment or hold, in that priority.
  always_comb begin
    w_nxt_pc        = r_pc;
    w_nxt_pend      = r_pend;
    w_nxt_pend_idx  = r_pend_idx;
    w_nxt_pend_addr = r_pend_addr;
    w_nxt_mis       = 1'b0;
    w_nxt_mis_addr  = r_mis_addr;
    if (w_tgt_mis) begin
      w_nxt_mis      = 1'b1;
      w_nxt_mis_addr = w_tgt;
      w_nxt_pend     = 1'b0;
    end else if (w_cand && !w_hold) begin
      w_nxt_pc   = w_tgt;
      w_nxt_pend = 1'b0;
    end else if (w_cand) begin
      w_nxt_pend      = 1'b1;
      w_nxt_pend_idx  = w_tgt_idx;
      w_nxt_pend_addr = w_tgt;
    end else if (w_adv) begin
      w_nxt_pc = r_pc + ADDR_W'(INC);
    end else begin
      w_nxt_pc = r_pc;
    end
  end

  // State registers; reset discards any deferred redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_VEC;
      r_valid     <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_idx  <= '0;
      r_pend_addr <= '0;
      r_mis       <= 1'b0;
      r_mis_addr  <= '0;
    end else begin
      r_pc        <= w_nxt_pc;
      r_valid     <= 1'b1;
      r_pend      <= w_nxt_pend;
      r_pend_idx  <= w_nxt_pend_idx;
      r_pend_addr <= w_nxt_pend_addr;
      r_mis       <= w_nxt_mis;
      r_mis_addr  <= w_nxt_mis_addr;
    end
  end

  assign pc_o            = r_pc;
  assign pc_valid_o      = r_valid;
  assign pend_o          = r_pend;
  assign misalign_o      = r_mis;
  assign misalign_addr_o = r_mis_addr;

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the fetch stage. It supersedes the single-branch PC register.
- Takes NUM_REDIR prioritised redirect channels (e.g. trap, jump, branch).
- Holds a redirect that arrives while fetch is stalled and applies it when the stall releases.
- Runs a valid/ready handshake toward the instruction fetch port.
- Flags misaligned redirect targets instead of loading them.

Parameters:
ADDR_W, 32, PC width in bits
RESET_VEC, 0, PC value after reset (must satisfy alignment)
NUM_REDIR, 3, number of redirect channels; index 0 = highest priority
INC, 4, sequential increment in bytes
ALIGN_BITS, 2, number of PC LSBs that must be zero (1 for compressed ISA)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
stall_i  in  1  pipeline stall (freezes PC, same meaning as stall bit 0 of the StallBus)
fetch_ready_i  in  1  fetch port accepts current pc_o
redir_en_i  in  NUM_REDIR  per-channel redirect request
redir_addr_i  in  NUM_REDIR*ADDR_W  packed targets; channel k at bits [k*ADDR_W +: ADDR_W]
pc_o  out  ADDR_W  current fetch address (registered)
pc_valid_o  out  1  pc_o is presentable to fetch
pend_o  out  1  a deferred redirect is held
misalign_o  out  1  one-cycle pulse: selected target violated alignment
misalign_addr_o  out  ADDR_W  offending target, valid while misalign_o=1

Behaviour:
- Reset (rst=1 at an edge): pc_o=RESET_VEC, pc_valid_o=0, pend_o=0, misalign_o=0, misalign_addr_o=0. Reset wins over every other input, including mid-stall with a pending redirect; the pending redirect is discarded.
- pc_valid_o rises to 1 on the first edge after rst deasserts and stays 1 until the next reset.
- adv = pc_valid_o & fetch_ready_i & !stall_i. The effective stall is hold = stall_i | !fetch_ready_i.
- Selection: sel = lowest index k with redir_en_i[k]=1; any = OR of redir_en_i. Combinational, no latency.
- Candidate choice:
  - If any=1 and pend_o=1, the pending entry wins only if its index is strictly lower than sel. Otherwise the new request wins.
  - If any=0, the pending entry is the candidate.
- Misalignment check on the chosen candidate: target[ALIGN_BITS-1:0] != 0.
  - Applies whenever a candidate would be loaded or latched.
  - misalign_o=1 next cycle and misalign_addr_o=target.
  - pc_o is unchanged and the pending entry is cleared.
  - Any other redirect requests in that cycle are dropped.
- Cycle update, in priority order:
  1. No candidate, adv=1: pc_o <= pc_o + INC, wrapping modulo 2^ADDR_W.
  2. No candidate, adv=0: pc_o holds.
  3. Candidate present, hold=0: pc_o <= target; pend_o <= 0. A redirect takes effect even if pc_valid_o=0 but rst=0.
  4. Candidate present, hold=1: store (index, target) in the pending entry; pend_o <= 1; pc_o holds.
- One redirect therefore costs one cycle: the target appears on pc_o the cycle after redir_en_i, or the cycle after the hold releases.
- The pending entry has depth 1 and may be overwritten by a higher-or-equal priority newer request. Equal index means newer wins.
- Sequential increment and redirect never combine in the same cycle; a redirect replaces the increment.
- misalign_o is cleared the following cycle unless a new misalignment occurs.

Decomposition:
- Shared package/define file:
  - ADDR_W default (tied to the InsAddrBus width)
  - RESET_VEC
  - Channel index constants: REDIR_TRAP=0, REDIR_JUMP=1, REDIR_BRANCH=2
  - Default NUM_REDIR
- One natural sub-module: redir_prio_sel.
  - Combinational fixed-priority encoder plus mux.
  - Outputs sel index, any, and selected address.
- The pending/compare/update logic stays in pc_gen.

Test Plan:
1. Reset release, RESET_VEC=0x100, stall_i=0, fetch_ready_i=1 for 4 cycles -> pc_o: 0x100 (valid rises), 0x104, 0x108, 0x10C. With fetch_ready_i=0 -> pc_o holds.
2. Simultaneous redir_en_i=3'b110, addr[1]=0x200, addr[2]=0x300 -> next pc_o=0x200. Then sequential 0x204.
3. stall_i=1, redirect ch2 to 0x400 -> pend_o=1, pc_o unchanged. Next cycle, still stalled, ch0 to 0x800 -> pending overwritten. Release stall -> pc_o=0x800, pend_o=0.
4. Pending ch0=0x800 under stall, then ch2=0x400 on the release cycle -> pending wins, pc_o=0x800.
5. Redirect ch1 to 0x202 with ALIGN_BITS=2 -> misalign_o=1 one cycle, misalign_addr_o=0x202, pc_o unchanged. Same stimulus with ALIGN_BITS=1 -> pc_o=0x202, no misalign.
6. pc_o=0xFFFF_FFFC, advance -> 0x0000_0000 (wrap). rst asserted while pend_o=1 -> pc_o=RESET_VEC, pend_o=0, and the pending target is never loaded.
